fp16_to_fp8_vector_quant: RTL and testbench

//  Quantises a 4-lane fp16 vector {d,c,b,a} (64b) into a packed fp8 vector (32b), E5M2 or E4M3 per beat.

---
 rtl/fp16_to_fp8_vector_quant_if.sv | 21 ++
 rtl/fp16_to_fp8_vector_quant.sv | 163 ++++++++++++++++
 tb/tb_fp16_to_fp8_vector_quant.sv | 252 +++++++++++++++++++++++++
 3 files changed

// File: rtl/fp16_to_fp8_vector_quant_if.sv
// Beat-level handshake bundle for the fp16 -> fp8 quantiser: fp16 input beat in, packed fp8 beat out.
interface fp16_to_fp8_vector_quant_if;
  logic        in_valid;
  logic        in_ready;
  logic        e5m2mode;
  logic [63:0] vec;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] res;
  logic        res_e5m2;

  modport master (
    output in_valid, e5m2mode, vec, out_ready,
    input  in_ready, out_valid, res, res_e5m2
  );

  modport slave (
    input  in_valid, e5m2mode, vec, out_ready,
    output in_ready, out_valid, res, res_e5m2
  );
endinterface

// File: rtl/fp16_to_fp8_vector_quant.sv
// Two-stage valid/ready quantiser: 4 fp16 lanes -> 4 fp8 lanes (E5M2 or E4M3 per beat), RNE rounding,
// optional saturation and a saturating count of overflowed lanes.
module fp16_to_fp8_vector_quant #(
  parameter bit          SATURATE = 1'b1,
  parameter int unsigned CNT_W    = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  fp16_to_fp8_vector_quant_if.slave bus,
  input  logic                      ovf_clr,
  output logic [CNT_W-1:0]          ovf_cnt
);
  localparam int unsigned SW = CNT_W + 1;

  logic s1_adv, s2_adv, out_fire;

  logic            s1_valid_q, s1_valid_d, s1_e5_q, s1_e5_d;
  logic [3:0]      s1_sign_q, s1_sign_d, s1_nan_q, s1_nan_d, s1_inf_q, s1_inf_d;
  logic [3:0]      s1_grd_q, s1_grd_d, s1_stk_q, s1_stk_d;
  logic [3:0][4:0] s1_base_q, s1_base_d;
  logic [3:0][3:0] s1_man_q, s1_man_d;

  logic             out_valid_q, out_valid_d, res_e5_q, res_e5_d;
  logic [31:0]      res_q, res_d;
  logic [3:0]       ovf_q, ovf_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign s2_adv   = !out_valid_q || bus.out_ready;
  assign s1_adv   = !s1_valid_q || s2_adv;
  assign out_fire = out_valid_q && bus.out_ready;

  // Stage 1: align each lane so that man holds hidden bit + fraction bits of the target format.
  // Values below the target min normal are shifted further right; base is then 0 so the fp8 subnormal
  // (and a round-up into min normal) falls out of the same base+man addition in stage 2.
  always_comb begin : p_unpack
    logic [15:0] h;
    logic [4:0]  ef;
    logic signed [6:0] e, emin;
    logic [3:0]  dsh, sh7;
    logic [20:0] w;
    s1_valid_d = s1_valid_q;
    s1_e5_d    = s1_e5_q;
    s1_sign_d  = s1_sign_q;
    s1_nan_d   = s1_nan_q;
    s1_inf_d   = s1_inf_q;
    s1_grd_d   = s1_grd_q;
    s1_stk_d   = s1_stk_q;
    s1_base_d  = s1_base_q;
    s1_man_d   = s1_man_q;
    h = '0; ef = '0; e = '0; emin = '0; dsh = '0; sh7 = '0; w = '0;
    if (s1_adv) begin
      s1_valid_d = bus.in_valid;
      if (bus.in_valid) begin
        s1_e5_d = bus.e5m2mode;
        for (int unsigned i = 0; i < 4; i++) begin
          h    = bus.vec[16*i +: 16];
          ef   = h[14:10];
          e    = (ef == 5'd0) ? -7'sd14 : $signed({2'b00, ef}) - 7'sd15;
          emin = bus.e5m2mode ? -7'sd14 : -7'sd6;
          dsh  = '0;
          s1_base_d[i] = '0;
          if (e < emin) dsh = 4'(emin - e);
          else          s1_base_d[i] = 5'(e + (bus.e5m2mode ? 7'sd14 : 7'sd6));
          sh7  = {3'b000, bus.e5m2mode} + dsh;
          w    = {ef != 5'd0, h[9:0], 10'b0} >> sh7;
          s1_sign_d[i] = h[15];
          s1_nan_d[i]  = (ef == 5'h1F) && (h[9:0] != '0);
          s1_inf_d[i]  = (ef == 5'h1F) && (h[9:0] == '0);
          s1_man_d[i]  = w[20:17];
          s1_grd_d[i]  = w[16];
          s1_stk_d[i]  = |w[15:0];
        end
      end
    end
  end

  // Stage 2: RNE, then code = (base << F) + man; the hidden bit and any rounding carry land in the
  // exponent field by plain addition.
  always_comb begin : p_round
    logic [4:0] qr;
    logic [8:0] code;
    logic       big;
    logic [6:0] satv;
    out_valid_d = out_valid_q;
    res_d       = res_q;
    res_e5_d    = res_e5_q;
    ovf_d       = ovf_q;
    qr = '0; code = '0; big = 1'b0;
    satv = SATURATE ? (s1_e5_q ? 7'h7B : 7'h7E) : (s1_e5_q ? 7'h7C : 7'h7F);
    if (s2_adv) begin
      out_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        res_e5_d = s1_e5_q;
        for (int unsigned i = 0; i < 4; i++) begin
          qr = {1'b0, s1_man_q[i]}
             + {4'b0000, s1_grd_q[i] & (s1_stk_q[i] | s1_man_q[i][0])};
          code = s1_e5_q ? ({2'b00, s1_base_q[i], 2'b00} + {4'b0000, qr})
                         : ({1'b0, s1_base_q[i], 3'b000} + {4'b0000, qr});
          big  = code > (s1_e5_q ? 9'd123 : 9'd126);
          ovf_d[i] = 1'b0;
          if (s1_nan_q[i]) begin
            res_d[8*i +: 8] = {s1_sign_q[i], 7'h7F};
          end else if (s1_inf_q[i] || big) begin
            res_d[8*i +: 8] = {s1_sign_q[i], satv};
            ovf_d[i] = 1'b1;
          end else begin
            res_d[8*i +: 8] = {s1_sign_q[i], code[6:0]};
          end
        end
      end
    end
  end

  always_comb begin : p_cnt
    logic [2:0]       pop;
    logic [CNT_W:0]   sum;
    pop = 3'(ovf_q[0]) + 3'(ovf_q[1]) + 3'(ovf_q[2]) + 3'(ovf_q[3]);
    sum = {1'b0, cnt_q} + SW'(pop);
    cnt_d = cnt_q;
    if (ovf_clr)       cnt_d = '0;
    else if (out_fire) cnt_d = sum[CNT_W] ? '1 : sum[CNT_W-1:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q  <= 1'b0;
      s1_e5_q     <= 1'b0;
      s1_sign_q   <= '0;
      s1_nan_q    <= '0;
      s1_inf_q    <= '0;
      s1_grd_q    <= '0;
      s1_stk_q    <= '0;
      s1_base_q   <= '0;
      s1_man_q    <= '0;
      out_valid_q <= 1'b0;
      res_e5_q    <= 1'b0;
      res_q       <= '0;
      ovf_q       <= '0;
      cnt_q       <= '0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_e5_q     <= s1_e5_d;
      s1_sign_q   <= s1_sign_d;
      s1_nan_q    <= s1_nan_d;
      s1_inf_q    <= s1_inf_d;
      s1_grd_q    <= s1_grd_d;
      s1_stk_q    <= s1_stk_d;
      s1_base_q   <= s1_base_d;
      s1_man_q    <= s1_man_d;
      out_valid_q <= out_valid_d;
      res_e5_q    <= res_e5_d;
      res_q       <= res_d;
      ovf_q       <= ovf_d;
      cnt_q       <= cnt_d;
    end
  end

  assign bus.in_ready  = s1_adv;
  assign bus.out_valid = out_valid_q;
  assign bus.res       = res_q;
  assign bus.res_e5m2  = res_e5_q;
  assign ovf_cnt       = cnt_q;
endmodule

// File: tb/tb_fp16_to_fp8_vector_quant.sv
// Bench for fp16_to_fp8_vector_quant: a saturating 16-bit-counter instance and a non-saturating
// 3-bit-counter instance share one stimulus stream and are checked against a real-valued model.
module tb_fp16_to_fp8_vector_quant;
  logic        clk = 1'b0;
  logic        rst;
  logic        ovf_clr;
  logic [15:0] ovf_cnt;
  logic [2:0]  ovf_cnt0;

  always #5 clk = ~clk;

  fp16_to_fp8_vector_quant_if bus ();
  fp16_to_fp8_vector_quant_if bus0 ();

  assign bus0.in_valid  = bus.in_valid;
  assign bus0.vec       = bus.vec;
  assign bus0.e5m2mode  = bus.e5m2mode;
  assign bus0.out_ready = bus.out_ready;

  fp16_to_fp8_vector_quant #(.SATURATE(1'b1), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .bus(bus), .ovf_clr(ovf_clr), .ovf_cnt(ovf_cnt)
  );

  fp16_to_fp8_vector_quant #(.SATURATE(1'b0), .CNT_W(3)) dut0 (
    .clk(clk), .rst(rst), .bus(bus0), .ovf_clr(ovf_clr), .ovf_cnt(ovf_cnt0)
  );

  typedef struct {
    logic [31:0] r1;
    logic [31:0] r0;
    logic        e5;
    int          nov;
    int          acc;
  } beat_t;

  beat_t q[$];
  int n_vec = 0;
  int n_err = 0;
  int stepn = 0;
  int cnt_m = 0;
  int cnt0_m = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (step %0d)", tag, got, exp, stepn);
    end
  endtask

  function automatic real p2(input int k);
    real r = 1.0;
    if (k >= 0) repeat (k) r = r * 2.0;
    else        repeat (-k) r = r / 2.0;
    return r;
  endfunction

  function automatic real fp16_mag(input logic [15:0] h);
    int ee = int'(h[14:10]);
    int mm = int'(h[9:0]);
    return (ee == 0) ? mm * p2(-24) : (1024 + mm) * p2(ee - 25);
  endfunction

  function automatic real fp8_mag(input int c, input bit e5);
    if (e5) return ((c >> 2) == 0) ? (c & 3) * p2(-16) : (4 + (c & 3)) * p2((c >> 2) - 17);
    return ((c >> 3) == 0) ? (c & 7) * p2(-9) : (8 + (c & 7)) * p2((c >> 3) - 10);
  endfunction

  // {overflow, fp8 byte}: round |x| to the nearest fp8 grid point (ties to even), then look it up.
  function automatic logic [8:0] ref_lane(input logic [15:0] h, input bit e5, input bit sat);
    real a, ulp, sc, mag;
    int k, emin, f, maxc, r;
    logic [6:0] satc;
    satc = sat ? (e5 ? 7'h7B : 7'h7E) : (e5 ? 7'h7C : 7'h7F);
    if (h[14:10] == 5'h1F)
      return (h[9:0] != 10'd0) ? {1'b0, h[15], 7'h7F} : {1'b1, h[15], satc};
    a    = fp16_mag(h);
    f    = e5 ? 2 : 3;
    emin = e5 ? -14 : -6;
    maxc = e5 ? 123 : 126;
    k    = emin;
    while (p2(k + 1) <= a) k++;
    ulp = p2(k - f);
    sc  = a / ulp;
    r   = $rtoi(sc);
    if ((sc - r > 0.5) || ((sc - r == 0.5) && (r % 2 == 1))) r++;
    mag = r * ulp;
    if (mag > fp8_mag(maxc, e5)) return {1'b1, h[15], satc};
    for (int c = 0; c <= maxc; c++)
      if (fp8_mag(c, e5) == mag) return {1'b0, h[15], 7'(c)};
    return {1'b0, h[15], 7'h55};
  endfunction

  function automatic beat_t mk_beat(input logic [63:0] v, input logic m, input int stp);
    beat_t b;
    logic [8:0] x1, x0;
    b.e5 = m; b.acc = stp; b.nov = 0; b.r1 = '0; b.r0 = '0;
    for (int i = 0; i < 4; i++) begin
      x1 = ref_lane(v[16*i +: 16], m, 1'b1);
      x0 = ref_lane(v[16*i +: 16], m, 1'b0);
      b.r1[8*i +: 8] = x1[7:0];
      b.r0[8*i +: 8] = x0[7:0];
      b.nov += int'(x1[8]);
    end
    return b;
  endfunction

  function automatic logic [15:0] rnd_lane();
    logic       s;
    logic [9:0] m;
    s = 1'($urandom);
    m = 10'($urandom);
    case ($urandom_range(0, 6))
      0: return 16'($urandom);
      1: return {s, 5'h1F, ($urandom_range(0, 1) == 0) ? 10'd0 : m};
      2: return {s, 5'(21 + $urandom_range(0, 3)), m};
      3: return {s, 5'(29 + $urandom_range(0, 1)), m};
      4: return {s, 5'($urandom_range(0, 10)), m};
      5: return ($urandom_range(0, 1) == 0) ? {s, 5'($urandom_range(6, 20)), m[9:7], 1'b1, 6'd0}
                                            : {s, 5'($urandom_range(1, 20)), m[9:8], 1'b1, 7'd0};
      default: return {s, 5'($urandom_range(12, 18)), m};
    endcase
  endfunction

  // One clock: drive at negedge, check/update model, then check the counters after the rising edge.
  // The head beat sits in the output register from two steps after it was accepted until it is taken.
  task automatic step(input logic iv, input logic [63:0] v, input logic m, input logic ordy,
                      input logic clr, output logic acc);
    logic ev, er, fire;
    @(negedge clk);
    bus.in_valid  = iv;
    bus.vec       = v;
    bus.e5m2mode  = m;
    bus.out_ready = ordy;
    ovf_clr       = clr;
    #1;
    ev = (q.size() > 0) && (stepn - q[0].acc >= 2);
    er = !((q.size() == 2) && !ordy);
    check("in_ready",     32'(bus.in_ready),   32'(er));
    check("in_ready_w3",  32'(bus0.in_ready),  32'(er));
    check("out_valid",    32'(bus.out_valid),  32'(ev));
    check("out_valid_w3", 32'(bus0.out_valid), 32'(ev));
    fire = ev && ordy;
    if (ev) begin
      check("res_sat",     bus.res,  q[0].r1);
      check("res_nosat",   bus0.res, q[0].r0);
      check("res_e5m2",    32'(bus.res_e5m2),  32'(q[0].e5));
      check("res_e5m2_w3", 32'(bus0.res_e5m2), 32'(q[0].e5));
    end
    if (clr) begin
      cnt_m = 0; cnt0_m = 0;
    end else if (fire) begin
      cnt_m  = (cnt_m + q[0].nov > 65535) ? 65535 : cnt_m + q[0].nov;
      cnt0_m = (cnt0_m + q[0].nov > 7) ? 7 : cnt0_m + q[0].nov;
    end
    if (fire) void'(q.pop_front());
    acc = iv && er;
    if (acc) q.push_back(mk_beat(v, m, stepn));
    @(posedge clk);
    #1;
    check("ovf_cnt",    32'(ovf_cnt),  32'(cnt_m));
    check("ovf_cnt_w3", 32'(ovf_cnt0), 32'(cnt0_m));
    stepn++;
  endtask

  task automatic drain();
    logic a;
    for (int i = 0; i < 12 && q.size() > 0; i++) step(1'b0, '0, 1'b0, 1'b1, 1'b0, a);
    check("drain_empty", 32'(q.size()), 32'd0);
  endtask

  logic [64:0] dirs [13];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
    $fatal(1);
  end

  initial begin
    logic a;
    int   sent;
    dirs = '{
      {1'b0, 64'hBC00_3E00_3C00_0000}, {1'b1, 64'hBC00_3E00_3C00_0000},
      {1'b1, 64'hBD80_3C40_3D80_3C80}, {1'b0, 64'h3CC0_3C40_BCC0_3C40},
      {1'b0, 64'hFBFF_7E00_7C00_7BFF}, {1'b1, 64'hFBFF_7E00_7C00_7BFF},
      {1'b0, 64'h5F80_5F40_5F00_5B80}, {1'b1, 64'h7B80_7B7F_7B00_7A00},
      {1'b0, 64'h8000_0001_1400_1800}, {1'b1, 64'h8000_03FF_0180_0001},
      {1'b0, 64'h23FF_2000_03FF_1C00}, {1'b0, 64'h7C00_FC00_7C00_FC00},
      {1'b1, 64'h7C00_FC00_7C00_FC00}
    };

    rst = 1'b1; ovf_clr = 1'b0;
    bus.in_valid = 1'b0; bus.vec = '0; bus.e5m2mode = 1'b0; bus.out_ready = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_out_valid",    32'(bus.out_valid),  32'd0);
    check("rst_out_valid_w3", 32'(bus0.out_valid), 32'd0);
    check("rst_res",          bus.res,             32'd0);
    check("rst_res_w3",       bus0.res,            32'd0);
    check("rst_res_e5m2",     32'(bus.res_e5m2),   32'd0);
    check("rst_ovf_cnt",      32'(ovf_cnt),        32'd0);
    check("rst_ovf_cnt_w3",   32'(ovf_cnt0),       32'd0);
    rst = 1'b0;

    // Directed encodings, back to back with the sink always ready.
    for (int i = 0; i < 13; i++) step(1'b1, dirs[i][63:0], dirs[i][64], 1'b1, 1'b0, a);
    drain();

    for (int i = 0; i < 400; i++)
      step($urandom_range(0, 3) != 0, {rnd_lane(), rnd_lane(), rnd_lane(), rnd_lane()},
           1'($urandom), $urandom_range(0, 3) != 0, $urandom_range(0, 29) == 0, a);
    drain();

    sent = 0;
    for (int k = 0; k < 100 && sent < 8; k++) begin
      step(1'b1, {rnd_lane(), rnd_lane(), rnd_lane(), rnd_lane()}, 1'($urandom),
           1'($urandom), 1'b0, a);
      if (a) sent++;
    end
    check("burst_accepted", 32'(sent), 32'd8);
    drain();

    // Reset with two beats in flight: they must vanish and the counter must clear.
    step(1'b1, 64'h7C00_7C00_7C00_7C00, 1'b1, 1'b0, 1'b0, a);
    step(1'b1, 64'h3C00_3C00_3C00_3C00, 1'b0, 1'b0, 1'b0, a);
    @(negedge clk);
    bus.in_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    check("arst_out_valid",    32'(bus.out_valid),  32'd0);
    check("arst_out_valid_w3", 32'(bus0.out_valid), 32'd0);
    check("arst_res",          bus.res,             32'd0);
    check("arst_ovf_cnt",      32'(ovf_cnt),        32'd0);
    check("arst_ovf_cnt_w3",   32'(ovf_cnt0),       32'd0);
    q.delete();
    cnt_m = 0; cnt0_m = 0;
    @(negedge clk);
    rst = 1'b0;
    repeat (3) step(1'b0, '0, 1'b0, 1'b1, 1'b0, a);

    step(1'b1, 64'h7C00_0000_0000_0000, 1'b1, 1'b1, 1'b0, a);
    drain();
    step(1'b1, 64'h7C00_7C00_0000_0000, 1'b0, 1'b1, 1'b0, a);
    step(1'b0, '0, 1'b0, 1'b1, 1'b0, a);
    step(1'b0, '0, 1'b0, 1'b1, 1'b1, a);
    check("clr_with_fire", 32'(q.size()), 32'd0);
    step(1'b0, '0, 1'b0, 1'b1, 1'b0, a);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
